// File: rtl/wb_pkg.sv
// Shared definitions for the MIPS write-back stage:
// opcode values, link register number and FSM state encoding.
package wb_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [4:0] REG_RA = 5'd31;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_WAIT_MEM = 1'b1
  } wb_state_t;

endpackage

// File: rtl/write_back_stage_op_decode.sv
// Combinational opcode decode for write-back: destination
// register, load/link flags and whether a real write happens.
module wb_op_decode
  import wb_pkg::*;
(
  input  logic [5:0] i_op,
  input  logic [4:0] i_rt,
  input  logic [4:0] i_rd,
  output logic [4:0] o_dest_reg,
  output logic       o_is_load,
  output logic       o_is_link,
  output logic       o_writes
);

  logic w_wr;

  always_comb begin
    o_dest_reg = '0;
    o_is_load  = 1'b0;
    o_is_link  = 1'b0;
    w_wr       = 1'b0;
    unique case (i_op)
      OP_RTYPE: begin
        o_dest_reg = i_rd;
        w_wr       = 1'b1;
      end
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: begin
        o_dest_reg = i_rt;
        w_wr       = 1'b1;
      end
      OP_LW: begin
        o_dest_reg = i_rt;
        o_is_load  = 1'b1;
        w_wr       = 1'b1;
      end
      OP_JAL: begin
        o_dest_reg = REG_RA;
        o_is_link  = 1'b1;
        w_wr       = 1'b1;
      end
      OP_SW, OP_BEQ, OP_BNE, OP_J: ;
      default: ;
    endcase
  end

  // r0 is hardwired zero, so it is never a real write target
  assign o_writes = w_wr && (o_dest_reg != 5'd0);

endmodule

// File: rtl/write_back_stage.sv
// MIPS write-back stage: owns the register-file write port,
// waits for load data with a timeout and counts retirements.
module write_back_stage
  import wb_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int COUNT_W     = 32
) (
  input  logic               clock,
  input  logic               resetN,
  input  logic               inValid,
  output logic               inReady,
  input  logic [5:0]         opCode,
  input  logic [4:0]         rt,
  input  logic [4:0]         rd,
  input  logic [31:0]        aluResult,
  input  logic [31:0]        pcPlus4,
  input  logic [31:0]        memReadData,
  input  logic               memDataValid,
  output logic               regWrite,
  output logic [4:0]         writeReg,
  output logic [31:0]        writeData,
  output logic               memTimeout,
  output logic [COUNT_W-1:0] retireCount
);

  localparam int CNT_W =
    (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LIMIT =
    CNT_W'(MEM_TIMEOUT - 1);

  wb_state_t          r_state;
  logic [4:0]         r_dest;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_reg_write;
  logic [4:0]         r_write_reg;
  logic [31:0]        r_write_data;
  logic               r_timeout;
  logic [COUNT_W-1:0] r_retire;

  logic [4:0] w_dest;
  logic       w_is_load;
  logic       w_is_link;
  logic       w_writes;
  logic       w_xfer;

  wb_op_decode u_dec (
    .i_op       (opCode),
    .i_rt       (rt),
    .i_rd       (rd),
    .o_dest_reg (w_dest),
    .o_is_load  (w_is_load),
    .o_is_link  (w_is_link),
    .o_writes   (w_writes)
  );

  assign inReady = (r_state == ST_IDLE);
  assign w_xfer  = inValid && inReady;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_state      <= ST_IDLE;
      r_dest       <= '0;
      r_cnt        <= '0;
      r_reg_write  <= 1'b0;
      r_write_reg  <= '0;
      r_write_data <= '0;
      r_timeout    <= 1'b0;
      r_retire     <= '0;
    end else begin
      r_reg_write <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_xfer && w_is_load) begin
            r_state <= ST_WAIT_MEM;
            r_dest  <= w_dest;
            r_cnt   <= '0;
          end else if (w_xfer) begin
            r_retire <= r_retire + COUNT_W'(1);
            if (w_writes) begin
              r_reg_write  <= 1'b1;
              r_write_reg  <= w_dest;
              r_write_data <= w_is_link ?
                pcPlus4 + 32'd4 : aluResult;
            end
          end
        end
        ST_WAIT_MEM: begin
          // data on the limit cycle takes priority over abort
          if (memDataValid) begin
            r_state  <= ST_IDLE;
            r_retire <= r_retire + COUNT_W'(1);
            if (r_dest != 5'd0) begin
              r_reg_write  <= 1'b1;
              r_write_reg  <= r_dest;
              r_write_data <= memReadData;
            end
          end else if (r_cnt == LIMIT) begin
            r_state   <= ST_IDLE;
            r_timeout <= 1'b1;
            r_retire  <= r_retire + COUNT_W'(1);
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

  assign regWrite    = r_reg_write;
  assign writeReg    = r_write_reg;
  assign writeData   = r_write_data;
  assign memTimeout  = r_timeout;
  assign retireCount = r_retire;

endmodule
